// File: rtl/rails_gen_if.sv
// Request/frame bundle for rails_gen.
//
// Handshake: start is a one-cycle request that is accepted only while busy is
// low; num/ops are sampled on that same edge and may change afterwards. The
// frame side has no ready: data is meaningful only while data_valid is high,
// words arrive on consecutive cycles without gaps, and the consumer must take
// every one. done (with err) is a one-cycle pulse closing each request.
interface rails_gen_if;
    logic        start;
    logic [3:0]  num;
    logic [19:0] ops;
    logic        busy;
    logic [3:0]  data;
    logic        data_valid;
    logic        done;
    logic        err;

    // Requester side: issues start/num/ops, consumes the frame.
    modport master (
        output start, num, ops,
        input  busy, data, data_valid, done, err
    );

    // Generator side: accepts the request, produces the frame.
    modport slave (
        input  start, num, ops,
        output busy, data, data_valid, done, err
    );
endinterface

// File: rtl/rails_gen.sv
// rails_gen: simulates a single-track stack station for cars 1..N driven by a
// push/pop operation string, then transmits the departure order as a frame
// (count word, then N car numbers on consecutive cycles). Illegal lengths,
// stack overflow (pushing beyond car N) and underflow (popping an empty
// stack) end the request with done+err and no frame words.
module rails_gen (
    input  logic             clk,
    input  logic             reset,
    rails_gen_if.slave       bus,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SIM    = 3'd1,
        S_SEND_N = 3'd2,
        S_SEND   = 3'd3,
        S_FIN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    // Latched request.
    logic [3:0]  r_num;
    logic [19:0] r_ops;

    // Station model: stack pointer, next arriving car, op index.
    logic [3:0]  r_sp;
    logic [3:0]  r_arr;
    logic [4:0]  r_idx;

    // Departure buffer write pointer and frame read pointer.
    logic [3:0]  r_dep_cnt;
    logic [3:0]  r_out_idx;

    // Storage; contents are meaningful only below the matching pointer.
    logic [3:0]  r_stack [0:9];
    logic [3:0]  r_dep   [0:9];

    // Decoded per-cycle signals.
    logic        w_op;
    logic        w_last;
    logic        w_num_ok;
    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_top;
    logic        w_busy_nx;
    logic        w_valid_nx;
    logic [3:0]  w_data_nx;
    logic        w_done_nx;
    logic        w_err_nx;

    assign o_dbg_state = r_state;

    // Decode the current operation and its legality.
    always_comb begin
        w_op     = r_ops[r_idx];
        w_last   = (r_idx == (({1'b0, r_num} << 1) - 5'd1));
        w_num_ok = (bus.num != 4'd0) && (bus.num <= 4'd10);
        w_top    = r_stack[r_sp - 4'd1];
        w_push   = (r_state == S_SIM) && w_op && (r_arr <= r_num);
        w_pop    = (r_state == S_SIM) && !w_op && (r_sp != 4'd0);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = w_num_ok ? S_SIM : S_ERR;
                end
            end
            S_SIM: begin
                if (w_op) begin
                    if (r_arr > r_num) begin
                        w_state_nx = S_ERR;
                    end else if (w_last) begin
                        w_state_nx = S_SEND_N;
                    end
                end else begin
                    if (r_sp == 4'd0) begin
                        w_state_nx = S_ERR;
                    end else if (w_last) begin
                        w_state_nx = S_SEND_N;
                    end
                end
            end
            S_SEND_N: begin
                w_state_nx = S_SEND;
            end
            S_SEND: begin
                // r_out_idx counts car words already issued.
                if (r_out_idx == r_num) begin
                    w_state_nx = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nx = S_IDLE;
            end
            S_ERR: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state so the
    // registered outputs line up exactly with the state they belong to.
    always_comb begin
        w_busy_nx  = (w_state_nx != S_IDLE);
        w_valid_nx = (w_state_nx == S_SEND_N) || (w_state_nx == S_SEND);
        w_done_nx  = (w_state_nx == S_FIN) || (w_state_nx == S_ERR);
        w_err_nx   = (w_state_nx == S_ERR);
        w_data_nx  = 4'd0;
        if (w_state_nx == S_SEND_N) begin
            w_data_nx = r_num;
        end else if (w_state_nx == S_SEND) begin
            w_data_nx = r_dep[r_out_idx];
        end
    end

    // Registered outputs; all read 0 as soon as reset asserts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.busy       <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.data       <= 4'd0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.busy       <= w_busy_nx;
            bus.data_valid <= w_valid_nx;
            bus.data       <= w_data_nx;
            bus.done       <= w_done_nx;
            bus.err        <= w_err_nx;
        end
    end

    // Request latch and station counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num     <= 4'd0;
            r_ops     <= 20'd0;
            r_sp      <= 4'd0;
            r_arr     <= 4'd1;
            r_idx     <= 5'd0;
            r_dep_cnt <= 4'd0;
            r_out_idx <= 4'd0;
        end else begin
            if ((r_state == S_IDLE) && bus.start) begin
                // Clearing the departure pointer empties the buffer.
                r_num     <= bus.num;
                r_ops     <= bus.ops;
                r_sp      <= 4'd0;
                r_arr     <= 4'd1;
                r_idx     <= 5'd0;
                r_dep_cnt <= 4'd0;
                r_out_idx <= 4'd0;
            end
            if (r_state == S_SIM) begin
                r_idx <= r_idx + 5'd1;
            end
            if (w_push) begin
                r_sp  <= r_sp + 4'd1;
                r_arr <= r_arr + 4'd1;
            end
            if (w_pop) begin
                r_sp      <= r_sp - 4'd1;
                r_dep_cnt <= r_dep_cnt + 4'd1;
            end
            if (w_state_nx == S_SEND) begin
                r_out_idx <= r_out_idx + 4'd1;
            end
        end
    end

    // Stack and departure storage; no reset needed, pointers guard reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp] <= r_arr;
        end
        if (w_pop) begin
            r_dep[r_dep_cnt] <= w_top;
        end
    end

endmodule

// File: tb/tb_rails_gen.sv
// Testbench for rails_gen: directed cases plus randomized requests checked by
// a scoreboard fed from a stack-station reference model.
module tb_rails_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] dbg_state;

    rails_gen_if bus();

    rails_gen dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [3:0] exp_q[$];
    int         exp_cyc_q[$];
    logic       exp_err_q[$];
    int         exp_done_cyc_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int base_done = 0;

    logic [3:0] mon_w;
    int         mon_c;
    logic       mon_e;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Observation convention: a value the spec places in cycle c is seen at
    // the falling edge that follows rising edge c-1, where cyc == c-1.
    task automatic model_push(input int k, input int n, input logic [19:0] o);
        int  stk[$];
        int  dep[$];
        int  nxt;
        bit  bad;
        int  err_at;
        nxt = 1;
        bad = 0;
        err_at = 0;
        if (n == 0 || n > 10) begin
            exp_err_q.push_back(1'b1);
            exp_done_cyc_q.push_back(k);
            return;
        end
        for (int i = 0; i < 2 * n; i++) begin
            if (o[i]) begin
                if (nxt > n) begin bad = 1; err_at = i; break; end
                stk.push_back(nxt);
                nxt++;
            end else begin
                if (stk.size() == 0) begin bad = 1; err_at = i; break; end
                dep.push_back(stk.pop_back());
            end
        end
        if (bad) begin
            exp_err_q.push_back(1'b1);
            exp_done_cyc_q.push_back(k + err_at + 1);
        end else begin
            exp_q.push_back(4'(n));
            exp_cyc_q.push_back(k + 2 * n);
            for (int m = 0; m < n; m++) begin
                exp_q.push_back(4'(dep[m]));
                exp_cyc_q.push_back(k + 2 * n + 1 + m);
            end
            exp_err_q.push_back(1'b0);
            exp_done_cyc_q.push_back(k + 3 * n + 1);
        end
    endtask

    function automatic logic [19:0] legal_ops(input int n);
        logic [19:0] r;
        int pushes;
        int depth;
        r = 20'd0;
        pushes = 0;
        depth = 0;
        for (int i = 0; i < 2 * n; i++) begin
            if (pushes < n && (depth == 0 || $urandom_range(0, 1) == 1)) begin
                r[i] = 1'b1;
                pushes++;
                depth++;
            end else begin
                depth--;
            end
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; start is sampled on the next rising edge.
    task automatic issue_req(input int n, input logic [19:0] o);
        int k;
        k = cyc + 1;
        base_done = done_cnt;
        model_push(k, n, o);
        bus.start = 1'b1;
        bus.num   = 4'(n);
        bus.ops   = o;
        @(negedge clk);
        check("busy_after_start", int'(bus.busy), 1);
        bus.start = 1'b0;
        bus.num   = 4'($urandom_range(0, 15));
        bus.ops   = 20'($urandom);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int t = 0; t < 200; t++) begin
            if (done_cnt > base_done) begin seen = 1; break; end
            @(negedge clk);
            #1;
        end
        check("done_within_budget", int'(seen), 1);
        @(negedge clk);
        check("busy_low_after_done", int'(bus.busy), 0);
    endtask

    task automatic wait_words_left(input int left);
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() <= left) break;
            @(negedge clk);
            #1;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data %0d at cycle %0d, required no word", bus.data, cyc);
                end else begin
                    mon_w = exp_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    check("frame_word", int'(bus.data), int'(mon_w));
                    check("frame_word_cycle", cyc, mon_c);
                end
            end else begin
                check("data_zero_when_invalid", int'(bus.data), 0);
            end
            if (bus.done) begin
                if (exp_err_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
                end else begin
                    mon_e = exp_err_q.pop_front();
                    mon_c = exp_done_cyc_q.pop_front();
                    check("done_err", int'(bus.err), int'(mon_e));
                    check("done_cycle", cyc, mon_c);
                end
                done_cnt++;
            end else begin
                check("err_without_done", int'(bus.err), 0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [19:0] o;
        bus.start = 1'b0;
        bus.num   = 4'd0;
        bus.ops   = 20'd0;
        #1;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_data", int'(bus.data), 0);
        check("reset_valid", int'(bus.data_valid), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_err", int'(bus.err), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Directed cases from the plan.
        issue_req(3, 20'h00007); wait_done();
        issue_req(3, 20'h00015); wait_done();
        issue_req(10, 20'h003FF); wait_done();
        issue_req(2, 20'h00000); wait_done();
        issue_req(2, 20'h00007); wait_done();
        issue_req(0, 20'h00003); wait_done();
        issue_req(11, 20'h00003); wait_done();

        // start during SEND must be ignored; the frame stays 3,3,2,1.
        issue_req(3, 20'h00007);
        wait_words_left(2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num   = 4'd2;
        bus.ops   = 20'h00005;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        // Reset in the middle of a num=5 frame.
        issue_req(5, 20'h0001F);
        wait_words_left(3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_data", int'(bus.data), 0);
        check("midreset_valid", int'(bus.data_valid), 0);
        check("midreset_done", int'(bus.done), 0);
        check("midreset_err", int'(bus.err), 0);
        exp_q.delete();
        exp_cyc_q.delete();
        exp_err_q.delete();
        exp_done_cyc_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_valid", int'(bus.data_valid), 0);
        check("post_reset_busy", int'(bus.busy), 0);
        issue_req(1, 20'h00001); wait_done();

        // Randomized requests, a mix of legal strings and raw random ones.
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 11);
            if (n >= 1 && n <= 10 && $urandom_range(0, 2) != 0) begin
                o = legal_ops(n);
            end else begin
                o = 20'($urandom);
            end
            issue_req(n, o);
            wait_done();
        end

        repeat (4) @(negedge clk);
        check("scoreboard_words_drained", exp_q.size(), 0);
        check("scoreboard_done_drained", exp_err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rails_gen.md
# rails_gen

Stimulus-side companion to the rails permutation checker. Given a train length and a push/pop operation string for a single-track station (stack), it simulates the station, records the departure order of cars 1..N, and transmits it as a frame: count first, then N car numbers on consecutive cycles. Its output frame is exactly the serial stream the checker consumes, so the two blocks can be chained for self-checking tests and system use.

## Interface

- Parameters: none. Maximum train length is fixed at 10 cars, so the stack depth is 10 × 4 bits.
- Ports:
  - clk  input  1  system clock, rising edge.
  - reset  input  1  asynchronous, active-high reset.
  - start  input  1  one-cycle request; sampled only in IDLE.
  - num  input  4  train length N; legal range 1..10; sampled with start.
  - ops  input  20  operation string; bit i is the i-th operation (1 = push next arriving car, 0 = pop top car to departure); bits 0..2N-1 are used; sampled with start.
  - busy  output  1  high in every state except IDLE.
  - data  output  4  frame word; 0 when data_valid is low.
  - data_valid  output  1  high on each frame word.
  - done  output  1  one-cycle completion pulse.
  - err  output  1  high with done when the request was illegal.

## Operation

- States: IDLE, SIM, SEND_N, SEND, FIN, ERR.
- IDLE: when start = 1, latch num and ops, clear the stack pointer, the next-arrival counter (starts at 1), the departure buffer and the op index. If num = 0 or num > 10, go to ERR. Otherwise go to SIM.
- SIM: consume one op per cycle, in order of increasing bit index.
  - Push: if the arrival counter is greater than N, this is an overflow: go to ERR. Otherwise write the counter value to the stack top and increment both.
  - Pop: if the stack is empty, this is an underflow: go to ERR. Otherwise append the top to the departure buffer and decrement the stack pointer.
  - After op index 2N-1 is processed without error, go to SEND_N. With exactly 2N ops and no error, the station has seen N pushes and N pops, so no end-of-string check is needed.
- SEND_N: data = N, data_valid = 1; go to SEND.
- SEND: drive departure buffer entries 0..N-1, one per cycle, with data_valid = 1; after entry N-1, go to FIN.
- FIN: done = 1, err = 0; go to IDLE.
- ERR: done = 1, err = 1, with no frame words emitted; go to IDLE.
- Widths: all counters are 4 bits; op index is 5 bits. Arithmetic never wraps within the legal range.

## Timing

- Reset (async): state = IDLE. busy, data, data_valid, done and err all read 0 immediately. Stack and buffer contents are don't-care.
- Reset asserted mid-operation aborts the request. No partial frame continues after reset is released.
- Outputs are registered from the state machine; done and err are single-cycle pulses.
- start sampled at edge k (legal N):
  - SIM spans cycles k+1 .. k+2N.
  - The count word is at cycle k+2N+1.
  - Car words are at cycles k+2N+2 .. k+3N+1.
  - done is at cycle k+3N+2.
  - IDLE again at cycle k+3N+3; a new start is accepted on that cycle.
- An error on op j (0-based) puts done/err at cycle k+j+2. An illegal num puts done/err at cycle k+1.
- start while busy is ignored. num and ops may change freely after the sampling edge.
- data_valid is continuous for N+1 cycles, with no gaps. This matches the checker's cycle-by-cycle read.

## Test plan

- num=3, ops=0x00007 (push ×3, pop ×3) -> frame 3,3,2,1, then done=1, err=0; total latency 11 cycles from start to done.
- num=3, ops=0x00015 (push/pop alternating) -> frame 3,1,2,3, then done=1, err=0.
- num=10, ops=0x003FF (10 pushes, 10 pops) -> frame 10,10,9,…,1 over 11 cycles, done at cycle k+32. Confirm the checker reports result=1.
- num=2, ops=0x00000 (pop first) -> no data_valid; done=1, err=1 at cycle k+2. num=2, ops=0x00007 (third op pushes car 3) -> err at cycle k+4.
- num=0 and num=11 -> err at cycle k+1, no frame. start pulsed during SEND -> ignored, and the frame is unchanged.
- Assert reset during SEND of a num=5 frame -> all outputs 0 immediately. After release, a fresh num=1, ops=0x1 request yields frame 1,1 and done.
